// File: rtl/oldland_mem_arbiter_pkg.sv
// rtl/oldland_mem_arbiter_pkg.sv - shared widths, arbiter state encodings and helpers
package oldland_mem_arbiter_pkg;

    localparam logic [1:0] MEM_WIDTH_32 = 2'b10;
    localparam logic [1:0] MEM_WIDTH_16 = 2'b01;
    localparam logic [1:0] MEM_WIDTH_8  = 2'b00;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BUSY_I = 2'd1,
        ARB_BUSY_D = 2'd2,
        ARB_ERR_D  = 2'd3
    } arb_state_t;

    typedef enum logic {
        GRANT_FETCH = 1'b0,
        GRANT_DATA  = 1'b1
    } grant_t;

    function automatic logic [31:0] word_addr(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/oldland_mem_arbiter_if.sv
// rtl/oldland_mem_arbiter_if.sv - external memory bus shared by fetch and LSU
interface oldland_mem_arbiter_if;
    logic        m_access;
    logic [31:0] m_addr;
    logic        m_wr_en;
    logic [31:0] m_wr_val;
    logic [3:0]  m_bytesel;
    logic        m_ack;
    logic [31:0] m_data;

    modport master (
        output m_access, m_addr, m_wr_en, m_wr_val, m_bytesel,
        input  m_ack, m_data
    );

    modport slave (
        input  m_access, m_addr, m_wr_en, m_wr_val, m_bytesel,
        output m_ack, m_data
    );
endinterface

// File: rtl/oldland_mem_arbiter_lane_align.sv
// rtl/oldland_mem_arbiter_lane_align.sv - byte lanes, write replication and read alignment
module oldland_lane_align
    import oldland_mem_arbiter_pkg::*;
(
    input  logic [1:0]  addr_i,
    input  logic [1:0]  width_i,
    input  logic [31:0] wr_val_i,
    input  logic [31:0] rd_raw_i,
    output logic [3:0]  bytesel_o,
    output logic [31:0] wr_rep_o,
    output logic [31:0] rd_aligned_o,
    output logic        misaligned_o
);

    always_comb begin
        bytesel_o    = 4'b0000;
        wr_rep_o     = wr_val_i;
        rd_aligned_o = 32'h0;
        misaligned_o = 1'b0;
        case (width_i)
            MEM_WIDTH_32: begin
                bytesel_o    = 4'b1111;
                rd_aligned_o = rd_raw_i;
                misaligned_o = |addr_i;
            end
            MEM_WIDTH_16: begin
                bytesel_o    = addr_i[1] ? 4'b1100 : 4'b0011;
                wr_rep_o     = {2{wr_val_i[15:0]}};
                rd_aligned_o = {16'h0, addr_i[1] ? rd_raw_i[31:16] : rd_raw_i[15:0]};
                misaligned_o = addr_i[0];
            end
            MEM_WIDTH_8: begin
                bytesel_o    = 4'b0001 << addr_i;
                wr_rep_o     = {4{wr_val_i[7:0]}};
                rd_aligned_o = {24'h0, rd_raw_i[{addr_i, 3'b000} +: 8]};
            end
            default: misaligned_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/oldland_mem_arbiter.sv
// rtl/oldland_mem_arbiter.sv - fetch/LSU arbiter for the single external memory port
module oldland_mem_arbiter
    import oldland_mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 256,
    parameter int TO_W    = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_access,
    input  logic [31:0]           i_addr,
    output logic                  i_ack,
    output logic [31:0]           i_data,
    output logic                  i_err,
    input  logic                  d_access,
    input  logic [31:0]           d_addr,
    input  logic                  d_wr_en,
    input  logic [31:0]           d_wr_val,
    input  logic [1:0]            d_width,
    output logic                  d_ack,
    output logic [31:0]           d_data,
    output logic                  d_err,
    oldland_mem_arbiter_if.master mem
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    arb_state_t      state_q, state_d;
    grant_t          last_q, last_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            m_access_q, m_access_d;
    logic [31:0]     m_addr_q, m_addr_d;
    logic            m_wr_en_q, m_wr_en_d;
    logic [31:0]     m_wr_val_q, m_wr_val_d;
    logic [3:0]      m_bytesel_q, m_bytesel_d;
    logic [1:0]      lo_q, lo_d;
    logic [1:0]      width_q, width_d;
    logic            i_ack_q, i_ack_d;
    logic [31:0]     i_data_q, i_data_d;
    logic            i_err_q, i_err_d;
    logic            d_ack_q, d_ack_d;
    logic [31:0]     d_data_q, d_data_d;
    logic            d_err_q, d_err_d;

    logic            i_elig, d_elig, win_data, win_fetch, timed_out;
    logic [1:0]      la_addr, la_width;
    logic [3:0]      la_bytesel;
    logic [31:0]     la_wr_rep, la_rd_aligned;
    logic            la_misaligned;
    logic            unused_addr_bits;

    assign unused_addr_bits = ^i_addr[1:0];

    // An ack still high means the requester has not yet seen its completion.
    assign i_elig    = i_access && !i_ack_q;
    assign d_elig    = d_access && !d_ack_q;
    assign win_data  = d_elig && (!i_elig || last_q == GRANT_FETCH);
    assign win_fetch = i_elig && !win_data;
    assign timed_out = (TIMEOUT != 0) && (cnt_q == TO_LAST);

    // Live LSU inputs drive lane selection at grant; captured offset/width align the read.
    assign la_addr  = (state_q == ARB_BUSY_D) ? lo_q    : d_addr[1:0];
    assign la_width = (state_q == ARB_BUSY_D) ? width_q : d_width;

    oldland_lane_align u_lane_align (
        .addr_i       (la_addr),
        .width_i      (la_width),
        .wr_val_i     (d_wr_val),
        .rd_raw_i     (mem.m_data),
        .bytesel_o    (la_bytesel),
        .wr_rep_o     (la_wr_rep),
        .rd_aligned_o (la_rd_aligned),
        .misaligned_o (la_misaligned)
    );

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        m_access_d  = m_access_q;
        m_addr_d    = m_addr_q;
        m_wr_en_d   = m_wr_en_q;
        m_wr_val_d  = m_wr_val_q;
        m_bytesel_d = m_bytesel_q;
        lo_d        = lo_q;
        width_d     = width_q;
        i_ack_d     = 1'b0;
        i_data_d    = i_data_q;
        i_err_d     = i_err_q;
        d_ack_d     = 1'b0;
        d_data_d    = d_data_q;
        d_err_d     = d_err_q;
        case (state_q)
            ARB_IDLE: begin
                if (win_data) begin
                    last_d = GRANT_DATA;
                    if (la_misaligned) begin
                        state_d  = ARB_ERR_D;
                        d_ack_d  = 1'b1;
                        d_err_d  = 1'b1;
                        d_data_d = 32'h0;
                    end else begin
                        state_d     = ARB_BUSY_D;
                        cnt_d       = '0;
                        m_access_d  = 1'b1;
                        m_addr_d    = word_addr(d_addr);
                        m_wr_en_d   = d_wr_en;
                        m_wr_val_d  = la_wr_rep;
                        m_bytesel_d = la_bytesel;
                        lo_d        = d_addr[1:0];
                        width_d     = d_width;
                    end
                end else if (win_fetch) begin
                    last_d      = GRANT_FETCH;
                    state_d     = ARB_BUSY_I;
                    cnt_d       = '0;
                    m_access_d  = 1'b1;
                    m_addr_d    = word_addr(i_addr);
                    m_wr_en_d   = 1'b0;
                    m_wr_val_d  = 32'h0;
                    m_bytesel_d = 4'b1111;
                end
            end
            ARB_BUSY_I: begin
                if (mem.m_ack || timed_out) begin
                    state_d    = ARB_IDLE;
                    m_access_d = 1'b0;
                    i_ack_d    = 1'b1;
                    i_err_d    = !mem.m_ack;
                    i_data_d   = mem.m_ack ? mem.m_data : 32'h0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ARB_BUSY_D: begin
                if (mem.m_ack || timed_out) begin
                    state_d    = ARB_IDLE;
                    m_access_d = 1'b0;
                    d_ack_d    = 1'b1;
                    d_err_d    = !mem.m_ack;
                    d_data_d   = (mem.m_ack && !m_wr_en_q) ? la_rd_aligned : 32'h0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ARB_ERR_D: state_d = ARB_IDLE;
            default:   state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB_IDLE;
            last_q      <= GRANT_FETCH;
            cnt_q       <= '0;
            m_access_q  <= 1'b0;
            m_addr_q    <= 32'h0;
            m_wr_en_q   <= 1'b0;
            m_wr_val_q  <= 32'h0;
            m_bytesel_q <= 4'b0000;
            lo_q        <= 2'b00;
            width_q     <= 2'b00;
            i_ack_q     <= 1'b0;
            i_data_q    <= 32'h0;
            i_err_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            d_data_q    <= 32'h0;
            d_err_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            m_access_q  <= m_access_d;
            m_addr_q    <= m_addr_d;
            m_wr_en_q   <= m_wr_en_d;
            m_wr_val_q  <= m_wr_val_d;
            m_bytesel_q <= m_bytesel_d;
            lo_q        <= lo_d;
            width_q     <= width_d;
            i_ack_q     <= i_ack_d;
            i_data_q    <= i_data_d;
            i_err_q     <= i_err_d;
            d_ack_q     <= d_ack_d;
            d_data_q    <= d_data_d;
            d_err_q     <= d_err_d;
        end
    end

    assign mem.m_access  = m_access_q;
    assign mem.m_addr    = m_addr_q;
    assign mem.m_wr_en   = m_wr_en_q;
    assign mem.m_wr_val  = m_wr_val_q;
    assign mem.m_bytesel = m_bytesel_q;
    assign i_ack         = i_ack_q;
    assign i_data        = i_data_q;
    assign i_err         = i_err_q;
    assign d_ack         = d_ack_q;
    assign d_data        = d_data_q;
    assign d_err         = d_err_q;

endmodule

// File: tb/tb_oldland_mem_arbiter.sv
// tb/tb_oldland_mem_arbiter.sv - directed and randomized bench for oldland_mem_arbiter
module tb_oldland_mem_arbiter;

    localparam int TB_TIMEOUT = 4;
    localparam int OWN_NONE = 0, OWN_I = 1, OWN_D = 2, OWN_ERR = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_access = 1'b0;
    logic [31:0] i_addr = 32'h0;
    logic        i_ack;
    logic [31:0] i_data;
    logic        i_err;
    logic        d_access = 1'b0;
    logic [31:0] d_addr = 32'h0;
    logic        d_wr_en = 1'b0;
    logic [31:0] d_wr_val = 32'h0;
    logic [1:0]  d_width = 2'b10;
    logic        d_ack;
    logic [31:0] d_data;
    logic        d_err;

    oldland_mem_arbiter_if mem();

    oldland_mem_arbiter #(.TIMEOUT(TB_TIMEOUT), .TO_W(9)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_access(i_access), .i_addr(i_addr), .i_ack(i_ack), .i_data(i_data), .i_err(i_err),
        .d_access(d_access), .d_addr(d_addr), .d_wr_en(d_wr_en), .d_wr_val(d_wr_val),
        .d_width(d_width), .d_ack(d_ack), .d_data(d_data), .d_err(d_err),
        .mem(mem)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: transaction owner, wait count and the expected visible outputs.
    int          own = OWN_NONE;
    int          waited = 0;
    bit          last_was_d = 1'b0;
    int          t_off, t_nb;
    bit          t_wr;
    logic        e_m_access, e_m_wr_en, e_i_ack, e_i_err, e_d_ack, e_d_err;
    logic [31:0] e_m_addr, e_m_wr_val, e_i_data, e_d_data;
    logic [3:0]  e_m_bytesel;

    function automatic int nbytes(input logic [1:0] w);
        case (w)
            2'b10:   return 4;
            2'b01:   return 2;
            2'b00:   return 1;
            default: return 0;
        endcase
    endfunction

    function automatic logic [3:0] lanes(input int off, input int nb);
        return 4'(((1 << nb) - 1) << off);
    endfunction

    function automatic logic [31:0] replicate(input logic [31:0] v, input int nb);
        logic [63:0] mask;
        logic [31:0] r;
        mask = (64'd1 << (8 * nb)) - 64'd1;
        r = 32'h0;
        for (int k = 0; k < 4 / nb; k++) r = r | ((v & mask[31:0]) << (8 * nb * k));
        return r;
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] raw, input int off, input int nb);
        logic [63:0] mask;
        mask = (64'd1 << (8 * nb)) - 64'd1;
        return (raw >> (8 * off)) & mask[31:0];
    endfunction

    task automatic model_reset();
        own = OWN_NONE; waited = 0; last_was_d = 1'b0;
        e_m_access = 0; e_m_wr_en = 0; e_m_addr = 0; e_m_wr_val = 0; e_m_bytesel = 0;
        e_i_ack = 0; e_i_err = 0; e_i_data = 0; e_d_ack = 0; e_d_err = 0; e_d_data = 0;
    endtask

    task automatic model_finish(input bit ok);
        e_m_access = 1'b0;
        if (own == OWN_I) begin
            e_i_ack = 1'b1; e_i_err = !ok; e_i_data = ok ? mem.m_data : 32'h0;
        end else begin
            e_d_ack = 1'b1; e_d_err = !ok;
            e_d_data = (ok && !t_wr) ? extract(mem.m_data, t_off, t_nb) : 32'h0;
        end
        own = OWN_NONE;
    endtask

    task automatic model_edge();
        bit fe, de, take_d, take_i;
        fe = i_access && !e_i_ack;
        de = d_access && !e_d_ack;
        e_i_ack = 1'b0;
        e_d_ack = 1'b0;
        if (own == OWN_NONE) begin
            take_d = de && (!fe || !last_was_d);
            take_i = fe && !take_d;
            if (take_d) begin
                last_was_d = 1'b1;
                t_nb = nbytes(d_width);
                t_off = int'(d_addr[1:0]);
                if (t_nb == 0 || (t_off % t_nb) != 0) begin
                    own = OWN_ERR; e_d_ack = 1'b1; e_d_err = 1'b1; e_d_data = 32'h0;
                end else begin
                    own = OWN_D; waited = 0; t_wr = d_wr_en;
                    e_m_access = 1'b1; e_m_addr = d_addr & ~32'h3; e_m_wr_en = d_wr_en;
                    e_m_wr_val = replicate(d_wr_val, t_nb); e_m_bytesel = lanes(t_off, t_nb);
                end
            end else if (take_i) begin
                last_was_d = 1'b0;
                own = OWN_I; waited = 0; t_wr = 1'b0; t_off = 0; t_nb = 4;
                e_m_access = 1'b1; e_m_addr = i_addr & ~32'h3; e_m_wr_en = 1'b0;
                e_m_wr_val = 32'h0; e_m_bytesel = 4'hF;
            end
        end else if (own == OWN_ERR) begin
            own = OWN_NONE;
        end else if (mem.m_ack) begin
            model_finish(1'b1);
        end else begin
            waited++;
            if (TB_TIMEOUT != 0 && waited == TB_TIMEOUT) model_finish(1'b0);
        end
    endtask

    // Bus responder and random requesters.
    int          busy_cyc = 0;
    int          lat = 1;
    int          dir_lat = 1;
    logic [31:0] dir_data = 32'h0;
    bit          rand_mem = 1'b0;
    bit          rand_req = 1'b0;
    bit          force_stray = 1'b0;

    task automatic new_d();
        d_width = ($urandom % 8 == 0) ? 2'b11 : 2'($urandom % 3);
        d_addr = $urandom;
        if ($urandom % 2 == 0) begin
            if (d_width == 2'b10) d_addr[1:0] = 2'b00;
            else if (d_width == 2'b01) d_addr[0] = 1'b0;
        end
        d_wr_en = 1'($urandom % 2);
        d_wr_val = $urandom;
    endtask

    task automatic drive_random();
        if (i_access) begin
            if (i_ack) begin i_access = ($urandom % 3 == 0); i_addr = $urandom; end
            else if ($urandom % 40 == 0) i_access = 1'b0;
        end else if ($urandom % 2 == 0) begin
            i_access = 1'b1; i_addr = $urandom;
        end
        if (d_access) begin
            if (d_ack) begin d_access = ($urandom % 3 == 0); new_d(); end
            else if ($urandom % 40 == 0) d_access = 1'b0;
        end else if ($urandom % 2 == 0) begin
            d_access = 1'b1; new_d();
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_val("m_access", mem.m_access, e_m_access);
        check_val("m_addr", mem.m_addr, e_m_addr);
        check_val("m_wr_en", mem.m_wr_en, e_m_wr_en);
        check_val("m_wr_val", mem.m_wr_val, e_m_wr_val);
        check_val("m_bytesel", mem.m_bytesel, e_m_bytesel);
        check_val("i_ack", i_ack, e_i_ack);
        check_val("i_data", i_data, e_i_data);
        check_val("i_err", i_err, e_i_err);
        check_val("d_ack", d_ack, e_d_ack);
        check_val("d_data", d_data, e_d_data);
        check_val("d_err", d_err, e_d_err);
        if (mem.m_access) begin
            busy_cyc++;
            if (busy_cyc == 1)
                lat = rand_mem ? (($urandom % 10 == 0) ? 0 : 1 + int'($urandom % 3)) : dir_lat;
            mem.m_ack = (busy_cyc == lat);
            mem.m_data = rand_mem ? $urandom : dir_data;
        end else begin
            busy_cyc = 0;
            mem.m_ack = force_stray || (rand_mem && ($urandom % 8 == 0));
            mem.m_data = $urandom;
        end
        if (rand_req) drive_random();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        i_access = 1'b0; d_access = 1'b0;
        mem.m_ack = 1'b0; force_stray = 1'b0; busy_cyc = 0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check_val("rst_m_access", mem.m_access, 0);
        check_val("rst_m_bytesel", mem.m_bytesel, 0);
        check_val("rst_i_ack", i_ack, 0);
        check_val("rst_d_ack", d_ack, 0);
        check_val("rst_d_data", d_data, 0);
        rst_n = 1'b1;
    endtask

    logic [31:0] exp_ord [4] = '{32'h200, 32'h100, 32'h200, 32'h100};
    logic [31:0] got_ord [4];

    initial begin
        int  ng, highcnt;
        bit  prev, got;
        mem.m_ack = 1'b0;
        mem.m_data = 32'h0;
        do_reset();

        // Fetch only
        dir_lat = 1; dir_data = 32'hDEADBEEF;
        i_addr = 32'h1000; i_access = 1'b1;
        step();
        check_val("f_m_access", mem.m_access, 1);
        check_val("f_bytesel", mem.m_bytesel, 4'hF);
        check_val("f_m_addr", mem.m_addr, 32'h1000);
        step();
        check_val("f_i_ack", i_ack, 1);
        check_val("f_i_data", i_data, 32'hDEADBEEF);
        check_val("f_i_err", i_err, 0);
        i_access = 1'b0;
        repeat (2) step();

        // Alternating grants with both requesters held
        do_reset();
        dir_data = 32'h11111111;
        i_addr = 32'h100; i_access = 1'b1;
        d_addr = 32'h200; d_width = 2'b10; d_wr_en = 1'b0; d_access = 1'b1;
        ng = 0; prev = 1'b0;
        for (int k = 0; k < 40 && ng < 4; k++) begin
            step();
            if (mem.m_access && !prev) begin got_ord[ng] = mem.m_addr; ng++; end
            prev = mem.m_access;
        end
        check_val("ord_count", ng, 4);
        for (int k = 0; k < 4; k++) check_val($sformatf("ord%0d", k), got_ord[k], exp_ord[k]);
        i_access = 1'b0; d_access = 1'b0;
        repeat (4) step();

        // Byte load and half store
        d_addr = 32'h2003; d_width = 2'b00; d_wr_en = 1'b0; d_access = 1'b1;
        dir_data = 32'hA1B2C3D4;
        step();
        check_val("bl_bytesel", mem.m_bytesel, 4'b1000);
        check_val("bl_m_addr", mem.m_addr, 32'h2000);
        step();
        check_val("bl_d_ack", d_ack, 1);
        check_val("bl_d_data", d_data, 32'h000000A1);
        d_access = 1'b0;
        step();
        d_addr = 32'h2002; d_width = 2'b01; d_wr_en = 1'b1; d_wr_val = 32'h1234ABCD; d_access = 1'b1;
        step();
        check_val("hs_bytesel", mem.m_bytesel, 4'b1100);
        check_val("hs_wr_val", mem.m_wr_val, 32'hABCDABCD);
        step();
        check_val("hs_d_ack", d_ack, 1);
        check_val("hs_d_data", d_data, 0);
        d_access = 1'b0;
        step();

        // Misaligned word and illegal width
        d_addr = 32'h2001; d_width = 2'b10; d_wr_en = 1'b0; d_access = 1'b1;
        step();
        check_val("mis_m_access", mem.m_access, 0);
        check_val("mis_d_ack", d_ack, 1);
        check_val("mis_d_err", d_err, 1);
        d_access = 1'b0;
        step();
        d_addr = 32'h2000; d_width = 2'b11; d_access = 1'b1;
        step();
        check_val("ill_m_access", mem.m_access, 0);
        check_val("ill_d_ack", d_ack, 1);
        check_val("ill_d_err", d_err, 1);
        d_access = 1'b0;
        repeat (2) step();

        // Timeout, stray late ack, then a normal fetch
        d_addr = 32'h4000; d_width = 2'b10; d_wr_en = 1'b0; d_access = 1'b1;
        dir_lat = 0; highcnt = 0; got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            step();
            if (mem.m_access) highcnt++;
            if (d_ack) got = 1'b1;
        end
        check_val("to_ack_seen", got, 1);
        check_val("to_high_cycles", highcnt, TB_TIMEOUT);
        check_val("to_d_err", d_err, 1);
        check_val("to_d_data", d_data, 0);
        d_access = 1'b0;
        force_stray = 1'b1;
        step();
        force_stray = 1'b0;
        step();
        check_val("stray_m_access", mem.m_access, 0);
        check_val("stray_i_ack", i_ack, 0);
        check_val("stray_d_ack", d_ack, 0);
        dir_lat = 2; dir_data = 32'hCAFEF00D;
        i_addr = 32'h5000; i_access = 1'b1; got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            step();
            if (i_ack) got = 1'b1;
        end
        check_val("post_to_ack", got, 1);
        check_val("post_to_data", i_data, 32'hCAFEF00D);
        check_val("post_to_err", i_err, 0);
        i_access = 1'b0;
        repeat (2) step();

        // Reset asserted mid-transaction
        i_addr = 32'h3000; i_access = 1'b1; dir_lat = 0;
        repeat (2) step();
        check_val("rm_busy", mem.m_access, 1);
        #2 rst_n = 1'b0;
        #1;
        check_val("rm_drop", mem.m_access, 0);
        check_val("rm_no_ack", i_ack, 0);
        i_access = 1'b0; mem.m_ack = 1'b0; busy_cyc = 0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check_val("rm_no_ack_late", i_ack, 0);
        rst_n = 1'b1;
        i_addr = 32'h3004; i_access = 1'b1; dir_lat = 1; dir_data = 32'h5A5A0F0F;
        repeat (2) step();
        check_val("rm_new_ack", i_ack, 1);
        check_val("rm_new_data", i_data, 32'h5A5A0F0F);
        check_val("rm_new_err", i_err, 0);
        i_access = 1'b0;
        step();

        // Randomized traffic against the model
        do_reset();
        rand_mem = 1'b1; rand_req = 1'b1;
        repeat (1500) step();
        rand_req = 1'b0; i_access = 1'b0; d_access = 1'b0;
        repeat (20) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
